i2c_master_multibyte: RTL and testbench
=======================================

// Module: i2c_master_multibyte
// PURPOSE
// Parametrised I2C master that runs one full transaction per Go pulse: START, 7-bit address + R/W,
//   then 0..MAX_BYTES data bytes written or read, then STOP.
// Checks every slave ACK, returns read data and flags NACK errors.
// Generates its own SCL; no external baud or controller blocks needed.
// Sits between a user FSM (e.g. TMP101 poller) and the board SDA/SCL pins.
// PARAMETERS
// CLOCK_FREQ  60000000  system clock frequency, Hz
// I2C_RATE    30000     SCL frequency, Hz; QDIV = CLOCK_FREQ/(4*I2C_RATE) clocks per quarter-bit, must be >=2
// MAX_BYTES   4         max data bytes per transaction; NBW = $clog2(MAX_BYTES+1)
// PORTS
// clock      in     1             system clock, all logic on rising edge
// Reset      in     1             synchronous, active-high
// Go         in     1             start request; sampled only in IDLE
// RnW        in     1             1 = read, 0 = write; latched with Go
// Address    in     7             slave address; latched with Go
// NumBytes   in     NBW           data byte count 0..MAX_BYTES; latched with Go, values >MAX_BYTES clamp to MAX_BYTES
// WriteData  in     8*MAX_BYTES   byte i = [8i+7:8i], sent byte 0 first, MSB first; latched with Go
// ReadData   out    8*MAX_BYTES   byte i received into [8i+7:8i]; bytes not read keep old value
// Busy       out    1             high from cycle after accepted Go through last STOP cycle
// Done       out    1             one-cycle pulse when STOP completes
// AckError   out    1             set on any slave NACK; cleared on next accepted Go
// SCL        out    1             I2C clock, idle 1
// SDA        inout  1             open drain: drives 0 or 1'bz only, never 1
// BEHAVIOUR
// Reset: Busy=0, Done=0, AckError=0, ReadData=0, SCL=1, SDA=z, FSM=IDLE, divider=0.
// Quarter tick every QDIV clocks while Busy; each bit slot = 4 quarters q0..q3.
//   q0,q1 SCL=0; q2,q3 SCL=1.
//   Master changes SDA at start of q0.
//   Sampling of SDA (ACK or read bit) on last clock of q2.
// States: IDLE -> START -> ADDR(8 slots) -> AACK -> {WBYTE,WACK}* or {RBYTE,MACK}* -> STOP -> IDLE.
// IDLE: Go=1 latches inputs, clears AckError, Busy=1 next cycle.
//   Go while Busy is ignored (no queueing).
// START slot: SCL=1 all 4 quarters; SDA z in q0-q1, 0 in q2-q3.
// ADDR: sends {Address,RnW} MSB first. AACK: SDA released.
//   Sampled 1 -> AckError=1, go STOP.
// NumBytes=0: after good AACK go straight to STOP (address probe).
// Write: each WBYTE is 8 slots then WACK; NACK on any byte -> AckError=1, STOP, remaining bytes skipped.
// Read: SDA released during RBYTE; MACK drives 0 (ACK) for bytes 0..N-2 and z (NACK) for last byte.
// STOP slot: SDA=0 q0-q1 with SCL=0 in q0 and 1 from q1; SDA released in q2-q3.
//   Done=1 and Busy=0 on cycle after q3.
// Slot count per transaction = 11 + 9*N.
// Transaction clocks = 4*QDIV*(11+9*N).
// Reset mid-transaction: abort immediately, outputs to reset values next cycle, no STOP generated.
// Go high on the same cycle Done pulses is ignored; Go is accepted from the next cycle onward.
// TESTING (sim: CLOCK_FREQ=4000000, I2C_RATE=100000 -> QDIV=10, 40 clocks/slot)
// Write 2 bytes: Go, Address=7'h48, RnW=0, N=2, WriteData[15:0]=16'hA503; slave ACKs all.
//   -> SDA bits 0x90,0x03,0xA5; Done at clock 1160; AckError=0.
// Read 2 bytes: Address=7'h48, RnW=1, N=2; slave sends 0x19,0x60.
//   -> ReadData[15:0]=16'h6019; master ACK after byte 0, NACK after byte 1; STOP seen.
// Address NACK: no slave present, Go, N=3. -> AckError=1, STOP right after AACK, Done at clock 440.
// Probe N=0 with ACK: -> 11 slots, Done at clock 440, AckError=0, no data slots.
// Go pulsed again mid-transaction. -> ignored; Reset asserted in ADDR slot 3: next cycle SCL=1, SDA=z, Busy=0, no Done.
// Protocol monitor all tests: SDA never changes while SCL=1 except START/STOP edges; SDA never driven 1.

Source files
------------

// File: rtl/i2c_master_multibyte.sv
// I2C master: one START/address/0..MAX_BYTES data/STOP transaction per Go pulse.
// SCL is generated internally from a quarter-bit divider; SDA is open drain.
module i2c_master_multibyte #(
    parameter int CLOCK_FREQ = 60000000,
    parameter int I2C_RATE   = 30000,
    parameter int MAX_BYTES  = 4,
    localparam int NBW = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clock,
    input  logic                   Reset,
    input  logic                   Go,
    input  logic                   RnW,
    input  logic [6:0]             Address,
    input  logic [NBW-1:0]         NumBytes,
    input  logic [8*MAX_BYTES-1:0] WriteData,
    output logic [8*MAX_BYTES-1:0] ReadData,
    output logic                   Busy,
    output logic                   Done,
    output logic                   AckError,
    output logic                   SCL,
    inout  wire                    SDA
);

    localparam int QDIV = CLOCK_FREQ / (4 * I2C_RATE);
    localparam int DW   = (QDIV > 1) ? $clog2(QDIV) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_WBYTE, S_WACK, S_RBYTE, S_MACK, S_STOP
    } state_t;

    state_t                 state, state_n;
    logic [DW-1:0]          div, div_n;
    logic [1:0]             qtr, qtr_n;
    logic [2:0]             bitcnt, bitcnt_n;
    logic [NBW-1:0]         bytecnt, bytecnt_n, nbytes, nbytes_n;
    logic                   rnw_q, rnw_n, nack_q, nack_n;
    logic [7:0]             shreg, shreg_n;
    logic [8*MAX_BYTES-1:0] wdata_q, wdata_n, wshift, rdata_n;
    logic                   done_n, ackerr_n;
    logic                   tick, sample, slot_end, last_byte, sda_low;

    assign tick      = (div == DW'(QDIV - 1));
    assign sample    = tick && (qtr == 2'd2);
    assign slot_end  = tick && (qtr == 2'd3);
    assign last_byte = (bytecnt == nbytes - NBW'(1));
    assign Busy      = (state != S_IDLE);

    always_ff @(posedge clock) begin
        if (Reset) begin
            state    <= S_IDLE;
            div      <= '0;
            qtr      <= '0;
            bitcnt   <= '0;
            bytecnt  <= '0;
            nbytes   <= '0;
            rnw_q    <= 1'b0;
            nack_q   <= 1'b0;
            shreg    <= '0;
            wdata_q  <= '0;
            ReadData <= '0;
            Done     <= 1'b0;
            AckError <= 1'b0;
        end else begin
            state    <= state_n;
            div      <= div_n;
            qtr      <= qtr_n;
            bitcnt   <= bitcnt_n;
            bytecnt  <= bytecnt_n;
            nbytes   <= nbytes_n;
            rnw_q    <= rnw_n;
            nack_q   <= nack_n;
            shreg    <= shreg_n;
            wdata_q  <= wdata_n;
            ReadData <= rdata_n;
            Done     <= done_n;
            AckError <= ackerr_n;
        end
    end

    always_comb begin
        state_n   = state;
        div_n     = div;
        qtr_n     = qtr;
        bitcnt_n  = bitcnt;
        bytecnt_n = bytecnt;
        nbytes_n  = nbytes;
        rnw_n     = rnw_q;
        nack_n    = nack_q;
        shreg_n   = shreg;
        wdata_n   = wdata_q;
        wshift    = wdata_q >> 8;
        rdata_n   = ReadData;
        done_n    = 1'b0;
        ackerr_n  = AckError;

        if (state == S_IDLE) begin
            div_n = '0;
            qtr_n = '0;
            // Done high marks the IDLE cycle right after STOP; Go is not taken there
            if (Go && !Done) begin
                state_n   = S_START;
                rnw_n     = RnW;
                nbytes_n  = (NumBytes > NBW'(MAX_BYTES)) ? NBW'(MAX_BYTES) : NumBytes;
                wdata_n   = WriteData;
                shreg_n   = {Address, RnW};
                bitcnt_n  = 3'd7;
                bytecnt_n = '0;
                ackerr_n  = 1'b0;
            end
        end else begin
            div_n = tick ? '0 : div + DW'(1);
            if (tick) qtr_n = qtr + 2'd1;
            if (sample) begin
                nack_n = SDA;
                if (state == S_RBYTE) shreg_n = {shreg[6:0], SDA};
            end
            if (slot_end) begin
                case (state)
                    S_START: state_n = S_ADDR;
                    S_ADDR, S_WBYTE: begin
                        shreg_n  = {shreg[6:0], 1'b0};
                        bitcnt_n = bitcnt - 3'd1;
                        if (bitcnt == 3'd0) state_n = (state == S_ADDR) ? S_AACK : S_WACK;
                    end
                    S_AACK: begin
                        bytecnt_n = '0;
                        if (nack_q) begin
                            ackerr_n = 1'b1;
                            state_n  = S_STOP;
                        end else if (nbytes == '0) begin
                            state_n = S_STOP;
                        end else if (rnw_q) begin
                            state_n = S_RBYTE;
                        end else begin
                            state_n = S_WBYTE;
                            shreg_n = wdata_q[7:0];
                        end
                    end
                    S_WACK: begin
                        if (nack_q) begin
                            ackerr_n = 1'b1;
                            state_n  = S_STOP;
                        end else if (last_byte) begin
                            state_n = S_STOP;
                        end else begin
                            bytecnt_n = bytecnt + NBW'(1);
                            wdata_n   = wshift;
                            shreg_n   = wshift[7:0];
                            state_n   = S_WBYTE;
                        end
                    end
                    S_RBYTE: begin
                        bitcnt_n = bitcnt - 3'd1;
                        if (bitcnt == 3'd0) begin
                            rdata_n[8*bytecnt +: 8] = shreg;
                            state_n = S_MACK;
                        end
                    end
                    S_MACK: begin
                        if (last_byte) begin
                            state_n = S_STOP;
                        end else begin
                            bytecnt_n = bytecnt + NBW'(1);
                            state_n   = S_RBYTE;
                        end
                    end
                    S_STOP: begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end
                    default: state_n = S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        SCL     = 1'b1;
        sda_low = 1'b0;
        case (state)
            S_START:         sda_low = qtr[1];
            S_ADDR, S_WBYTE: begin SCL = qtr[1]; sda_low = !shreg[7]; end
            S_MACK:          begin SCL = qtr[1]; sda_low = !last_byte; end
            S_AACK, S_WACK, S_RBYTE: SCL = qtr[1];
            S_STOP:          begin SCL = (qtr != 2'd0); sda_low = !qtr[1]; end
            default: ;
        endcase
    end

    assign SDA = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_multibyte.sv
// Directed bench for i2c_master_multibyte with a behavioural I2C slave and START/STOP monitor.
module tb_i2c_master_multibyte;

    logic        clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Go = 1'b0;
    logic        RnW = 1'b0;
    logic [6:0]  Address = '0;
    logic [2:0]  NumBytes = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic        Busy, Done, AckError, SCL;
    wire         SDA;

    logic slave_low = 1'b0;
    logic sda_bus;
    pullup (SDA);
    assign SDA     = slave_low ? 1'b0 : 1'bz;
    assign sda_bus = (SDA === 1'b0) ? 1'b0 : 1'b1;

    i2c_master_multibyte #(
        .CLOCK_FREQ(4000000),
        .I2C_RATE  (100000),
        .MAX_BYTES (4)
    ) dut (
        .clock    (clock),
        .Reset    (Reset),
        .Go       (Go),
        .RnW      (RnW),
        .Address  (Address),
        .NumBytes (NumBytes),
        .WriteData(WriteData),
        .ReadData (ReadData),
        .Busy     (Busy),
        .Done     (Done),
        .AckError (AckError),
        .SCL      (SCL),
        .SDA      (SDA)
    );

    always #5 clock = ~clock;

    // Slave configuration (written by the stimulus only)
    logic       slave_present = 1'b1;
    int         nack_frame = 99;
    logic [7:0] rd_bytes [0:7];

    // Slave / monitor state
    logic       scl_p = 1'b1, sda_p = 1'b1;
    logic       s_active = 1'b0, s_in_ack = 1'b0, s_is_read = 1'b0;
    logic       s_match = 1'b0, s_mack = 1'b1, s_tx = 1'b0;
    int         s_bitn = 0, s_frame = 0;
    logic [7:0] s_rx = '0;
    int         start_cnt = 0, stop_cnt = 0, rx_n = 0;
    logic [7:0] rx_log [0:31];
    logic       mack_log [0:7];

    always @(negedge clock) begin
        scl_p <= SCL;
        sda_p <= sda_bus;
        if (scl_p && SCL && sda_p && !sda_bus) begin
            start_cnt <= start_cnt + 1;
            s_active  <= 1'b1;
            s_bitn    <= 0;
            s_frame   <= 0;
            s_in_ack  <= 1'b0;
            s_tx      <= 1'b0;
            slave_low <= 1'b0;
        end else if (scl_p && SCL && !sda_p && sda_bus) begin
            stop_cnt  <= stop_cnt + 1;
            s_active  <= 1'b0;
            s_tx      <= 1'b0;
            slave_low <= 1'b0;
        end else if (s_active && !scl_p && SCL) begin
            if (s_in_ack) begin
                s_mack <= sda_bus;
                if (s_is_read && s_frame > 0 && s_frame < 9) mack_log[s_frame-1] <= sda_bus;
            end else begin
                s_rx   <= {s_rx[6:0], sda_bus};
                s_bitn <= s_bitn + 1;
            end
        end else if (s_active && scl_p && !SCL) begin
            if (s_in_ack) begin
                s_in_ack  <= 1'b0;
                s_bitn    <= 0;
                s_frame   <= s_frame + 1;
                s_tx      <= 1'b0;
                slave_low <= 1'b0;
                if (s_is_read && s_match && (s_frame == 0 || !s_mack) && s_frame < 8) begin
                    s_tx      <= 1'b1;
                    slave_low <= !rd_bytes[s_frame][7];
                end
            end else if (s_bitn == 8) begin
                s_in_ack  <= 1'b1;
                slave_low <= 1'b0;
                if (s_frame == 0 || !s_is_read) begin
                    if (rx_n < 32) rx_log[rx_n] <= s_rx;
                    rx_n <= rx_n + 1;
                end
                if (s_frame == 0) begin
                    s_is_read <= s_rx[0];
                    s_match   <= slave_present && (s_rx[7:1] == 7'h48);
                    slave_low <= slave_present && (s_rx[7:1] == 7'h48);
                end else if (!s_is_read) begin
                    slave_low <= s_match && (s_frame != nack_frame);
                end
            end else if (s_tx && s_bitn >= 1 && s_bitn <= 7 && s_frame >= 1 && s_frame < 9) begin
                slave_low <= !rd_bytes[s_frame-1][7-s_bitn];
            end
        end
    end

    int passed = 0;
    int total  = 0;
    int done_at;
    int st0, sp0, rx0;
    logic seen_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        st0 = start_cnt;
        sp0 = stop_cnt;
        rx0 = rx_n;
    endtask

    // Issues Go, then counts rising edges after the accepting edge until Done.
    task automatic run_txn(input logic [6:0] a, input logic rnw, input logic [2:0] n,
                           input logic [31:0] wd, input logic pulse_go, output int d_at);
        Address   = a;
        RnW       = rnw;
        NumBytes  = n;
        WriteData = wd;
        @(posedge clock); #1;
        Go = 1'b1;
        @(posedge clock); #1;
        Go = 1'b0;
        check("busy_after_go", {31'd0, Busy}, 32'd1);
        d_at = -1;
        for (int k = 1; k <= 2500; k++) begin
            @(posedge clock); #1;
            if (pulse_go && k == 300) Go = 1'b1;
            if (pulse_go && k == 301) Go = 1'b0;
            if (Done) begin
                d_at = k;
                break;
            end
        end
        check("busy_at_done", {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rd_bytes[i] = 8'h00;
        rd_bytes[0] = 8'h19;
        rd_bytes[1] = 8'h60;

        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_ackerr", {31'd0, AckError}, 32'd0);
        check("rst_rdata", ReadData, 32'd0);
        check("rst_scl", {31'd0, SCL}, 32'd1);
        check("rst_sda", {31'd0, sda_bus}, 32'd1);
        Reset = 1'b0;

        // Write two bytes, all ACKed
        snap();
        run_txn(7'h48, 1'b0, 3'd2, 32'h0000A503, 1'b0, done_at);
        check("wr_done_at", done_at, 32'd1160);
        check("wr_ackerr", {31'd0, AckError}, 32'd0);
        check("wr_nbytes", rx_n - rx0, 32'd3);
        check("wr_byte_addr", {24'd0, rx_log[rx0]}, 32'h90);
        check("wr_byte0", {24'd0, rx_log[rx0+1]}, 32'h03);
        check("wr_byte1", {24'd0, rx_log[rx0+2]}, 32'hA5);
        check("wr_starts", start_cnt - st0, 32'd1);
        check("wr_stops", stop_cnt - sp0, 32'd1);

        // Read two bytes, with a stray Go mid-transaction
        snap();
        run_txn(7'h48, 1'b1, 3'd2, 32'h0, 1'b1, done_at);
        check("rd_done_at", done_at, 32'd1160);
        check("rd_data", ReadData, 32'h00006019);
        check("rd_addr", {24'd0, rx_log[rx0]}, 32'h91);
        check("rd_mack0", {31'd0, mack_log[0]}, 32'd0);
        check("rd_mack1", {31'd0, mack_log[1]}, 32'd1);
        check("rd_ackerr", {31'd0, AckError}, 32'd0);
        check("rd_starts", start_cnt - st0, 32'd1);
        check("rd_stops", stop_cnt - sp0, 32'd1);

        // Address NACK
        slave_present = 1'b0;
        snap();
        run_txn(7'h48, 1'b0, 3'd3, 32'h00112233, 1'b0, done_at);
        check("anack_done_at", done_at, 32'd440);
        check("anack_ackerr", {31'd0, AckError}, 32'd1);
        check("anack_stops", stop_cnt - sp0, 32'd1);
        slave_present = 1'b1;

        // Address probe, then Go held during the Done cycle
        snap();
        run_txn(7'h48, 1'b0, 3'd0, 32'h0, 1'b0, done_at);
        check("probe_done_at", done_at, 32'd440);
        check("probe_ackerr", {31'd0, AckError}, 32'd0);
        check("probe_nbytes", rx_n - rx0, 32'd1);
        Go = 1'b1;
        @(posedge clock); #1;
        Go = 1'b0;
        check("godone_busy", {31'd0, Busy}, 32'd0);
        check("done_pulse_len", {31'd0, Done}, 32'd0);
        @(posedge clock); #1;
        check("godone_busy2", {31'd0, Busy}, 32'd0);

        // NumBytes above MAX_BYTES clamps to 4
        snap();
        run_txn(7'h48, 1'b0, 3'd7, 32'h44332211, 1'b0, done_at);
        check("clamp_done_at", done_at, 32'd1880);
        check("clamp_nbytes", rx_n - rx0, 32'd5);
        check("clamp_byte0", {24'd0, rx_log[rx0+1]}, 32'h11);
        check("clamp_byte3", {24'd0, rx_log[rx0+4]}, 32'h44);

        // Slave NACKs data byte 1 of 3
        nack_frame = 2;
        snap();
        run_txn(7'h48, 1'b0, 3'd3, 32'h00CCBBAA, 1'b0, done_at);
        check("wnack_done_at", done_at, 32'd1160);
        check("wnack_ackerr", {31'd0, AckError}, 32'd1);
        check("wnack_nbytes", rx_n - rx0, 32'd3);
        check("wnack_stops", stop_cnt - sp0, 32'd1);
        nack_frame = 99;

        // Reset during address slot 3 aborts without STOP
        snap();
        Address   = 7'h48;
        RnW       = 1'b0;
        NumBytes  = 3'd2;
        WriteData = 32'h0000BEEF;
        @(posedge clock); #1;
        Go = 1'b1;
        @(posedge clock); #1;
        Go = 1'b0;
        repeat (170) @(posedge clock);
        #1;
        check("abort_busy_before", {31'd0, Busy}, 32'd1);
        Reset = 1'b1;
        @(posedge clock); #1;
        check("abort_scl", {31'd0, SCL}, 32'd1);
        check("abort_sda", {31'd0, sda_bus}, 32'd1);
        check("abort_busy", {31'd0, Busy}, 32'd0);
        check("abort_done", {31'd0, Done}, 32'd0);
        check("abort_rdata", ReadData, 32'd0);
        Reset = 1'b0;
        seen_done = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clock); #1;
            if (Done) seen_done = 1'b1;
        end
        check("abort_no_done", {31'd0, seen_done}, 32'd0);
        check("abort_starts", start_cnt - st0, 32'd1);
        check("abort_stops", stop_cnt - sp0, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
